branch_compare_seq: RTL and testbench

- Multi-cycle, parametrised successor to the single-cycle branch comparator; same role in the branch-resolution path.
- Compares rs1/rs2 CHUNK bits per cycle, MSB chunk first; exits early on the first differing chunk.
- Decodes RV32I branch funct3 into br_taken.
- Valid/ready handshake on both sides, so it can sit in a multi-cycle or area-reduced core.

---
 rtl/branch_compare_seq_if.sv | 28 ++
 rtl/branch_compare_seq.sv | 193 +++++++++++++++++++
 tb/tb_branch_compare_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/branch_compare_seq_if.sv
// Handshake and operand bus for branch_compare_seq.
// master: the requester/consumer side; slave: the comparator itself.
interface branch_compare_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [2:0]       funct3;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             BrEq;
    logic             BrLT;
    logic             br_taken;
    logic             br_err;

    modport master (
        output in_valid, rs1, rs2, funct3, flush, out_ready,
        input  in_ready, out_valid, BrEq, BrLT, br_taken, br_err
    );

    modport slave (
        input  in_valid, rs1, rs2, funct3, flush, out_ready,
        output in_ready, out_valid, BrEq, BrLT, br_taken, br_err
    );
endinterface

// File: rtl/branch_compare_seq.sv
// Multi-cycle branch comparator: compares rs1/rs2 CHUNK bits per cycle,
// MSB chunk first, and decodes the RV32I branch funct3 into br_taken.
//
// Optional feature macro: BRCMP_EARLY_EXIT_EN
//   defined   - the first differing chunk ends the compare (latency 1..NCHUNK)
//   undefined - every compare walks all NCHUNK chunks (constant latency);
//               the first difference is held in a sticky flag so the final
//               result matches the early-exit build.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CMP   | walking chunks from idx = NCHUNK-1 down to 0
// DONE  | result held on the outputs until out_ready or flush
module branch_compare_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_compare_seq_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0) begin : gChunkCheck
        $error("branch_compare_seq: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state, stateNext;
    logic [IDXW-1:0]  idx, idxNext;
    logic [WIDTH-1:0] rs1Q, rs2Q;
    logic [2:0]       funct3Q;
    logic             load;
    logic             brEqQ, brEqNext;
    logic             brLtQ, brLtNext;
    logic             takenQ, takenNext;
    logic             errQ, errNext;
`ifndef BRCMP_EARLY_EXIT_EN
    logic             decidedQ, decidedNext;
    logic             ltStickyQ, ltStickyNext;
`endif

    logic [CHUNK-1:0] chunk1, chunk2;
    logic             signedSel, chunkDiff, chunkLt;
    logic             finish, resEq, resLt;

    assign chunk1    = rs1Q[int'(idx)*CHUNK +: CHUNK];
    assign chunk2    = rs2Q[int'(idx)*CHUNK +: CHUNK];
    // Only the top chunk carries the sign; lower chunks are plain magnitude.
    assign signedSel = (idx == IDX_TOP) && !funct3Q[1];
    assign chunkDiff = (chunk1 != chunk2);
    assign chunkLt   = signedSel ? ($signed(chunk1) < $signed(chunk2))
                                 : (chunk1 < chunk2);

    function automatic logic takenOf(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:         takenOf = eq;
            3'b001:         takenOf = !eq;
            3'b100, 3'b110: takenOf = lt;
            3'b101, 3'b111: takenOf = !lt;
            default:        takenOf = 1'b0;
        endcase
    endfunction

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.BrEq      = brEqQ;
    assign bus.BrLT      = brLtQ;
    assign bus.br_taken  = takenQ;
    assign bus.br_err    = errQ;

    // Next-state, chunk walk and result computation.
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        load      = 1'b0;
        finish    = 1'b0;
        resEq     = 1'b0;
        resLt     = 1'b0;
        brEqNext  = brEqQ;
        brLtNext  = brLtQ;
        takenNext = takenQ;
        errNext   = errQ;
`ifndef BRCMP_EARLY_EXIT_EN
        decidedNext  = decidedQ;
        ltStickyNext = ltStickyQ;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load      = 1'b1;
                    idxNext   = IDX_TOP;
                    stateNext = CMP;
`ifndef BRCMP_EARLY_EXIT_EN
                    decidedNext  = 1'b0;
                    ltStickyNext = 1'b0;
`endif
                end
            end
            CMP: begin
                if (bus.flush) begin
                    stateNext = IDLE;
                end else begin
`ifdef BRCMP_EARLY_EXIT_EN
                    if (chunkDiff) begin
                        finish = 1'b1;
                        resEq  = 1'b0;
                        resLt  = chunkLt;
                    end else if (idx == '0) begin
                        finish = 1'b1;
                        resEq  = 1'b1;
                        resLt  = 1'b0;
                    end else begin
                        idxNext = idx - 1'b1;
                    end
`else
                    if (!decidedQ && chunkDiff) begin
                        decidedNext  = 1'b1;
                        ltStickyNext = chunkLt;
                    end
                    if (idx == '0) begin
                        finish = 1'b1;
                        resEq  = !(decidedQ || chunkDiff);
                        resLt  = decidedQ ? ltStickyQ : (chunkDiff && chunkLt);
                    end else begin
                        idxNext = idx - 1'b1;
                    end
`endif
                    if (finish) begin
                        stateNext = DONE;
                        brEqNext  = resEq;
                        brLtNext  = resLt;
                        takenNext = takenOf(funct3Q, resEq, resLt);
                        errNext   = (funct3Q[2:1] == 2'b01);
                    end
                end
            end
            DONE: begin
                if (bus.flush || bus.out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, chunk index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= IDX_TOP;
            brEqQ   <= 1'b0;
            brLtQ   <= 1'b0;
            takenQ  <= 1'b0;
            errQ    <= 1'b0;
`ifndef BRCMP_EARLY_EXIT_EN
            decidedQ  <= 1'b0;
            ltStickyQ <= 1'b0;
`endif
        end else begin
            state   <= stateNext;
            idx     <= idxNext;
            brEqQ   <= brEqNext;
            brLtQ   <= brLtNext;
            takenQ  <= takenNext;
            errQ    <= errNext;
`ifndef BRCMP_EARLY_EXIT_EN
            decidedQ  <= decidedNext;
            ltStickyQ <= ltStickyNext;
`endif
        end
    end

    // Operand capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1Q    <= '0;
            rs2Q    <= '0;
            funct3Q <= '0;
        end else if (load) begin
            rs1Q    <= bus.rs1;
            rs2Q    <= bus.rs2;
            funct3Q <= bus.funct3;
        end
    end
endmodule

// File: tb/tb_branch_compare_seq.sv
// Directed bench for branch_compare_seq (WIDTH=32, CHUNK=8).
module tb_branch_compare_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    branch_compare_seq_if #(.WIDTH(32)) bus ();

    branch_compare_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        eq;
        logic        lt;
        logic        taken;
        logic        err;
        int          latEarly;
    } vecT;

    vecT vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int expLat(input int latEarly);
`ifdef BRCMP_EARLY_EXIT_EN
        return latEarly;
`else
        return 4;
`endif
    endfunction

    // Issue one request and return cycles from the accept edge until out_valid (-1 on timeout).
    task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.rs1      = a;
        bus.rs2      = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.rs1      = ~a;
        bus.rs2      = a;
        bus.funct3   = ~f3;
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) lat = c;
        end
    endtask

    task automatic releaseResult(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, " out_valid after accept"}, 32'(bus.out_valid), 32'd0);
        check({name, " in_ready after accept"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{"BEQ equal",        3'b000, 32'h12345678, 32'h12345678, 1, 0, 1, 0, 4};
        vecs[1]  = '{"BLT -1<1",         3'b100, 32'hFFFFFFFF, 32'h00000001, 0, 1, 1, 0, 1};
        vecs[2]  = '{"BLTU ff..>1",      3'b110, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, 1};
        vecs[3]  = '{"BGEU ff..>1",      3'b111, 32'hFFFFFFFF, 32'h00000001, 0, 0, 1, 0, 1};
        vecs[4]  = '{"BNE idx1",         3'b001, 32'h00000102, 32'h00000201, 0, 1, 1, 0, 3};
        vecs[5]  = '{"err 010",          3'b010, 32'h00000005, 32'h00000005, 1, 0, 0, 1, 4};
        vecs[6]  = '{"BGE min<max",      3'b101, 32'h80000000, 32'h7FFFFFFF, 0, 1, 0, 0, 1};
        vecs[7]  = '{"BGEU 8..>7f..",    3'b111, 32'h80000000, 32'h7FFFFFFF, 0, 0, 1, 0, 1};
        vecs[8]  = '{"BLT low chunk",    3'b100, 32'h00000080, 32'h00000001, 0, 0, 0, 0, 4};
        vecs[9]  = '{"err 011",          3'b011, 32'h00000001, 32'h00000002, 0, 1, 0, 1, 4};
        vecs[10] = '{"BEQ lsb differs",  3'b000, 32'h12345678, 32'h12345679, 0, 1, 0, 0, 4};

        bus.in_valid  = 1'b0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.funct3    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset outputs", {28'd0, bus.BrEq, bus.BrLT, bus.br_taken, bus.br_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            runOp(vecs[i].f3, vecs[i].a, vecs[i].b, lat);
            check({vecs[i].name, " latency"}, 32'(lat), 32'(expLat(vecs[i].latEarly)));
            check({vecs[i].name, " BrEq"}, 32'(bus.BrEq), 32'(vecs[i].eq));
            check({vecs[i].name, " BrLT"}, 32'(bus.BrLT), 32'(vecs[i].lt));
            check({vecs[i].name, " br_taken"}, 32'(bus.br_taken), 32'(vecs[i].taken));
            check({vecs[i].name, " br_err"}, 32'(bus.br_err), 32'(vecs[i].err));
            releaseResult(vecs[i].name);
        end

        // Backpressure: result held while out_ready is low.
        runOp(3'b100, 32'hFFFFFFFF, 32'h00000001, lat);
        check("bp latency", 32'(lat), 32'(expLat(1)));
        for (int c = 0; c < 5; c++) begin
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp in_ready", 32'(bus.in_ready), 32'd0);
            check("bp results", {29'd0, bus.BrEq, bus.BrLT, bus.br_taken}, 32'b011);
            @(posedge clk); #1;
        end
        releaseResult("bp");
        check("bp results kept in IDLE", {29'd0, bus.BrEq, bus.BrLT, bus.br_taken}, 32'b011);

        // Flush in the second CMP cycle drops the request.
        bus.in_valid = 1'b1;
        bus.funct3   = 3'b000;
        bus.rs1      = 32'hCAFEF00D;
        bus.rs2      = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        check("flush out_valid in CMP", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush in_ready next", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        check("flush no out_valid", 32'(seen), 32'd0);
        check("flush results untouched", {29'd0, bus.BrEq, bus.BrLT, bus.br_taken}, 32'b011);

        // Load a nonzero result, then reset in the middle of a compare.
        runOp(3'b000, 32'h5A5A5A5A, 32'h5A5A5A5A, lat);
        check("pre-reset BrEq", 32'(bus.BrEq), 32'd1);
        releaseResult("pre-reset");
        bus.in_valid = 1'b1;
        bus.funct3   = 3'b010;
        bus.rs1      = 32'h11111111;
        bus.rs2      = 32'h11111111;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst outputs", {28'd0, bus.BrEq, bus.BrLT, bus.br_taken, bus.br_err}, 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("rst no out_valid", 32'(seen), 32'd0);
        check("rst idle in_ready", 32'(bus.in_ready), 32'd1);

        // Post-reset operation still works.
        runOp(3'b101, 32'h00000003, 32'h00000003, lat);
        check("post-reset latency", 32'(lat), 32'(expLat(4)));
        check("post-reset BGE taken", {29'd0, bus.BrEq, bus.BrLT, bus.br_taken}, 32'b101);
        releaseResult("post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
